// File: rtl/mips_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS main control FSM and its datapath.
// The master modport is the FSM: it reads the opcode, jump_reg and mem_ready status and drives every datapath control.
interface mips_control_fsm_if;
  logic [5:0]  opcode;
  logic        jump_reg;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        BranchNe;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        ZeroExt;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic [2:0]  ALUOp;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  opcode, jump_reg, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ALUSrcA, ZeroExt, RegDst, MemtoReg, ALUSrcB, PCSource,
           ALUOp, state, illegal, retired
  );

  modport slave (
    output opcode, jump_reg, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ALUSrcA, ZeroExt, RegDst, MemtoReg, ALUSrcB, PCSource,
           ALUOp, state, illegal, retired
  );
endinterface

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main control: a Moore FSM sequencing fetch/decode/execute/memory/write-back.
// It drives every datapath enable and counts retired instructions.
module mips_control_fsm (
  input  logic                      clk,
  input  logic                      rst,
  mips_control_fsm_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB    = 4'd7,
    S_BEQ    = 4'd8,  S_BNE    = 4'd9,  S_JUMP   = 4'd10, S_JAL    = 4'd11,
    S_JR     = 4'd12, S_IMMEX  = 4'd13, S_IMMWB  = 4'd14, S_UNUSED = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LW  = 6'h23,
                         OP_SW    = 6'h2B;

  state_t      state_q, state_d;
  logic [31:0] retired_q;
  logic        retire;
  logic        pc_write, pc_write_cond, ir_write, mem_write, reg_write;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_q + {31'd0, retire};
    end
  end

  // Only completed instructions count; the illegal-opcode bounce out of DECODE does not.
  assign retire = (state_d == S_FETCH) &&
                  !(state_q inside {S_FETCH, S_DECODE, S_UNUSED});

  // NOTE: every output and next-state is defaulted first so no path can infer a latch.
  always_comb begin
    state_d          = S_FETCH;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    ir_write         = 1'b0;
    mem_write        = 1'b0;
    reg_write        = 1'b0;
    bus.BranchNe     = 1'b0;
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ZeroExt      = 1'b0;
    bus.RegDst       = 2'b00;
    bus.MemtoReg     = 2'b00;
    bus.ALUSrcB      = 2'b00;
    bus.PCSource     = 2'b00;
    bus.ALUOp        = 3'b000;
    bus.illegal      = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        ir_write    = bus.mem_ready;
        pc_write    = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_RTYPE:                 state_d = bus.jump_reg ? S_JR : S_REX;
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_BEQ:                   state_d = S_BEQ;
          OP_BNE:                   state_d = S_BNE;
          OP_J:                     state_d = S_JUMP;
          OP_JAL:                   state_d = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          default: begin
            state_d     = S_FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        bus.IorD  = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_REX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'b010;
        state_d     = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        bus.RegDst = 2'b01;
      end
      S_BEQ, S_BNE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = 3'b001;
        pc_write_cond = 1'b1;
        bus.PCSource  = 2'b01;
        bus.BranchNe  = (state_q == S_BNE);
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_JAL: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b10;
        reg_write    = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b10;
      end
      S_JR: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b11;
      end
      S_IMMEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.opcode)
          OP_ANDI: begin bus.ALUOp = 3'b011; bus.ZeroExt = 1'b1; end
          OP_ORI:  begin bus.ALUOp = 3'b100; bus.ZeroExt = 1'b1; end
          default: bus.ALUOp = 3'b000;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: reg_write = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural write strobes are suppressed for the whole reset cycle, whatever the state.
  assign bus.PCWrite     = pc_write      & ~rst;
  assign bus.PCWriteCond = pc_write_cond & ~rst;
  assign bus.IRWrite     = ir_write      & ~rst;
  assign bus.MemWrite    = mem_write     & ~rst;
  assign bus.RegWrite    = reg_write     & ~rst;
  assign bus.state       = state_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class through its state sequence.
module tb_mips_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mips_control_fsm_if bus ();
  mips_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Packed view of all controls:
  // {PCWrite,PCWriteCond,BranchNe,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,ZeroExt,
  //  RegDst,MemtoReg,ALUSrcB,PCSource,ALUOp,illegal}
  function automatic logic [21:0] ctl();
    return {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ALUSrcA, bus.ZeroExt,
            bus.RegDst, bus.MemtoReg, bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.opcode = 6'h00; bus.jump_reg = 1'b0; bus.mem_ready = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d retired=%0d expected 0/0", bus.state, bus.retired);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl() !== 22'b0000100000_00_00_01_00_000_0) begin
      failures++;
      $display("FAIL fetch_idle_ctl: got %b expected %b", ctl(), 22'b0000100000_00_00_01_00_000_0);
    end
    tick();
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL fetch_wait: state=%0d expected 0", bus.state);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    bus.opcode = 6'h00; bus.jump_reg = 1'b0; bus.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state !== seq[i]) begin
        failures++;
        $display("FAIL rtype_state[%0d]: state=%0d expected %0d", i, bus.state, seq[i]);
      end
      if (i == 0) begin
        checks++;
        if (ctl() !== 22'b1000101000_00_00_01_00_000_0) begin
          failures++;
          $display("FAIL fetch_ready_ctl: got %b expected %b", ctl(), 22'b1000101000_00_00_01_00_000_0);
        end
      end
      if (i == 2) begin
        checks++;
        if (bus.ALUOp !== 3'b010 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00) begin
          failures++;
          $display("FAIL rex_ctl: ALUOp=%b ALUSrcA=%b ALUSrcB=%b expected 010/1/00", bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b01 || bus.MemtoReg !== 2'b00) begin
          failures++;
          $display("FAIL rwb_ctl: RegWrite=%b RegDst=%b MemtoReg=%b expected 1/01/00", bus.RegWrite, bus.RegDst, bus.MemtoReg);
        end
      end
      if (i < 4) tick();
    end
    checks++;
    if (bus.retired !== 32'd1) begin
      failures++;
      $display("FAIL rtype_retired: retired=%0d expected 1", bus.retired);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] seq [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       mr  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      #1;
      checks++;
      if (bus.state !== seq[i]) begin
        failures++;
        $display("FAIL lw_state[%0d]: state=%0d expected %0d", i, bus.state, seq[i]);
      end
      if (i >= 3 && i <= 5) begin
        checks++;
        if (bus.MemRead !== 1'b1 || bus.IorD !== 1'b1 || bus.RegWrite !== 1'b0) begin
          failures++;
          $display("FAIL memrd_ctl[%0d]: MemRead=%b IorD=%b RegWrite=%b expected 1/1/0", i, bus.MemRead, bus.IorD, bus.RegWrite);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus.MemtoReg !== 2'b01 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'b00) begin
          failures++;
          $display("FAIL memwb_ctl: MemtoReg=%b RegWrite=%b RegDst=%b expected 01/1/00", bus.MemtoReg, bus.RegWrite, bus.RegDst);
        end
      end
      if (i < 7) tick();
    end
    checks++;
    if (bus.retired !== 32'd2) begin
      failures++;
      $display("FAIL lw_retired: retired=%0d expected 2", bus.retired);
    end
  endtask

  task automatic test_ori();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd13, 4'd14, 4'd0};
    bus.opcode = 6'h0D; bus.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.state !== seq[i]) begin
        failures++;
        $display("FAIL ori_state[%0d]: state=%0d expected %0d", i, bus.state, seq[i]);
      end
      if (i == 2) begin
        checks++;
        if (ctl() !== 22'b0000000011_00_00_10_00_100_0) begin
          failures++;
          $display("FAIL immex_ori_ctl: got %b expected %b", ctl(), 22'b0000000011_00_00_10_00_100_0);
        end
      end
      if (i == 3) begin
        checks++;
        if (ctl() !== 22'b0000000100_00_00_00_00_000_0) begin
          failures++;
          $display("FAIL immwb_ctl: got %b expected %b", ctl(), 22'b0000000100_00_00_00_00_000_0);
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_short(input logic [5:0] op, input logic jr, input logic [3:0] exec_state,
                            input logic [21:0] exec_ctl, input logic [31:0] exp_retired);
    bus.opcode = op; bus.jump_reg = jr; bus.mem_ready = 1'b1;
    #1;
    tick();
    tick();
    checks++;
    if (bus.state !== exec_state || ctl() !== exec_ctl) begin
      failures++;
      $display("FAIL exec_op%02h: state=%0d ctl=%b expected %0d/%b", op, bus.state, ctl(), exec_state, exec_ctl);
    end
    tick();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== exp_retired) begin
      failures++;
      $display("FAIL retire_op%02h: state=%0d retired=%0d expected 0/%0d", op, bus.state, bus.retired, exp_retired);
    end
    bus.jump_reg = 1'b0;
  endtask

  task automatic test_illegal();
    bus.opcode = 6'h3F; bus.mem_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (bus.state !== 4'd1 || bus.illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_decode: state=%0d illegal=%b expected 1/1", bus.state, bus.illegal);
    end
    tick();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd6 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_return: state=%0d retired=%0d illegal=%b expected 0/6/0", bus.state, bus.retired, bus.illegal);
    end
  endtask

  task automatic test_retired_wrap();
    bus.opcode = 6'h02; bus.mem_ready = 1'b1;
    #1;
    tick();
    tick();
    checks++;
    if (bus.state !== 4'd10 || bus.PCWrite !== 1'b1 || bus.PCSource !== 2'b10) begin
      failures++;
      $display("FAIL jump_ctl: state=%0d PCWrite=%b PCSource=%b expected 10/1/10", bus.state, bus.PCWrite, bus.PCSource);
    end
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    tick();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd0) begin
      failures++;
      $display("FAIL retired_wrap: state=%0d retired=%h expected 0/00000000", bus.state, bus.retired);
    end
  endtask

  task automatic test_reset_in_memwr();
    logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.state !== seq[i]) begin
        failures++;
        $display("FAIL sw_state[%0d]: state=%0d expected %0d", i, bus.state, seq[i]);
      end
      if (i < 3) tick();
    end
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b1 || bus.IorD !== 1'b1) begin
      failures++;
      $display("FAIL memwr_ctl: MemWrite=%b IorD=%b expected 1/1", bus.MemWrite, bus.IorD);
    end
    tick();
    checks++;
    if (bus.state !== 4'd5) begin
      failures++;
      $display("FAIL memwr_wait: state=%0d expected 5", bus.state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.state !== 4'd5) begin
      failures++;
      $display("FAIL memwr_rst_gate: MemWrite=%b state=%0d expected 0/5", bus.MemWrite, bus.state);
    end
    bus.mem_ready = 1'b1;
    tick();
    checks++;
    if (bus.state !== 4'd0 || bus.retired !== 32'd0 || bus.PCWrite !== 1'b0 || bus.IRWrite !== 1'b0) begin
      failures++;
      $display("FAIL rst_fetch_gate: state=%0d retired=%0d PCWrite=%b IRWrite=%b expected 0/0/0/0",
               bus.state, bus.retired, bus.PCWrite, bus.IRWrite);
    end
    tick();
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL rst_priority: state=%0d expected 0", bus.state);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_ori();
    // jr: PCWrite, PCSource=11
    test_short(6'h00, 1'b1, 4'd12, 22'b1000000000_00_00_00_11_000_0, 32'd4);
    // bne: PCWriteCond, BranchNe, ALUSrcA, PCSource=01, ALUOp=001
    test_short(6'h05, 1'b0, 4'd9,  22'b0110000010_00_00_00_01_001_0, 32'd5);
    // jal: PCWrite, RegWrite, RegDst=10, MemtoReg=10, PCSource=10
    test_short(6'h03, 1'b0, 4'd11, 22'b1000000100_10_10_00_10_000_0, 32'd6);
    test_illegal();
    test_retired_wrap();
    test_reset_in_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multi-cycle MIPS main control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction and drives every datapath enable. It is the producer of the 3-bit ALUOp code that the ALU control decoder consumes. It also takes back that decoder's JumpReg flag to resolve `jr`. It sits between the instruction register opcode field and the datapath muxes, register file and memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH completes
- jump_reg  in  1  JumpReg from the ALU control decoder (`func == 0x08` with ALUOp 010)
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ZeroExt  out  1 each  datapath controls
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUSrcB  out  2  00 regB, 01 const 4, 10 extended imm, 11 signext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- ALUOp  out  3  000 add, 001 sub, 010 func field, 011 and, 100 or
- state  out  4  current state encoding, for debug
- illegal  out  1  unknown opcode in DECODE
- retired  out  32  count of completed instructions

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, BNE=9, JUMP=10, JAL=11, JR=12, IMMEX=13, IMMWB=14. Code 15 is unreachable and goes to FETCH.
- Outputs are decoded from state, plus opcode in IMMEX. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=000, PCSource=00, IRWrite=PCWrite=mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=000. Next state by opcode:
  - 0x00 with jump_reg=1 → JR; 0x00 otherwise → REX
  - 0x23/0x2B → MEMADR
  - 0x04 → BEQ; 0x05 → BNE
  - 0x02 → JUMP; 0x03 → JAL
  - 0x08/0x0C/0x0D → IMMEX
  - any other opcode → FETCH, with illegal=1 for that cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then → FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=010 → RWB. RWB: RegWrite=1, RegDst=01, MemtoReg=00.
- BEQ/BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. BranchNe=1 in BNE only.
- JUMP: PCWrite=1, PCSource=10.
- JAL: same as JUMP, plus RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4).
- JR: PCWrite=1, PCSource=11.
- IMMEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000/011/100 for 0x08/0x0C/0x0D. ZeroExt=1 for 0x0C/0x0D. → IMMWB.
- IMMWB: RegWrite=1, RegDst=00, MemtoReg=00.
- MEMWB, RWB, BEQ, BNE, JUMP, JAL, JR and IMMWB all return to FETCH. MEMWR returns to FETCH on mem_ready.
- retired increments by 1 on every transition into FETCH from any state other than FETCH, DECODE and the unreachable code 15. It wraps from 0xFFFFFFFF to 0. The illegal-opcode path does not count.

## Timing
- Reset takes effect on the clock edge where rst=1: state=FETCH and retired=0.
- While rst=1, PCWrite, PCWriteCond, IRWrite, MemWrite and RegWrite are forced to 0 regardless of state. This includes a reset arriving mid-MEMWR or mid-FETCH.
- After reset is released, outputs are the FETCH decode: MemRead=1, ALUSrcB=01, all others 0.
- rst has priority over mem_ready and over every transition.
- Cycles per instruction with mem_ready held at 1:
  - lw: 5
  - R-type, sw, addi/andi/ori: 4
  - beq, bne, j, jal, jr: 3
- Each cycle of mem_ready=0 adds one cycle in FETCH, MEMRD or MEMWR. Enables stay asserted, and write strobes stay gated by state.
- jump_reg is sampled only in DECODE.

## Test plan
- Reset, then opcode=0x00, jump_reg=0, mem_ready=1 → state sequence 0,1,6,7,0. ALUOp=010 in REX. RegWrite=1 and RegDst=01 in RWB. retired=1.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. MemRead=IorD=1 throughout MEMRD. MemtoReg=01 in MEMWB.
- ori (0x0D) → ALUOp=100 and ZeroExt=1 in IMMEX. jr (0x00, jump_reg=1) → JR with PCSource=11 and PCWrite=1.
- Opcode 0x3F → illegal=1 in DECODE, next state FETCH, retired unchanged.
- Assert rst in MEMWR with mem_ready=0 → MemWrite=0 that cycle. state=0 and retired=0 after the edge.
- Preload retired to 0xFFFFFFFF by forcing the register, then retire a j (0x02) → retired=0.
